// File: rtl/flt2int_pkg.sv
// Shared types and constants for the half-float to integer converter.
package flt2int_pkg;

  localparam int BIAS   = 15;
  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int MAG_W  = 15;

  localparam logic [EXP_W-1:0] EXP_SAT   = 5'd30;
  localparam logic [EXP_W-1:0] EXP_UNITY = 5'(BIAS + MANT_W);
  localparam logic [EXP_W-1:0] EXP_HALF  = 5'd14;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    ROUND,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    K_ZERO,
    K_SAT,
    K_SHIFT,
    K_ROUND
  } kind_t;

  typedef struct packed {
    logic              sgn;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } half_t;

endpackage

// File: rtl/flt2int_classify.sv
// Maps a biased exponent to the conversion path, shift direction
// and shift distance.
module flt2int_classify
  import flt2int_pkg::*;
(
  input  logic [EXP_W-1:0] exp_in,
  output kind_t            kind,
  output logic             dir_left,
  output logic [3:0]       count
);

  always_comb begin
    kind     = K_ZERO;
    dir_left = 1'b0;
    count    = 4'd0;
    unique case (1'b1)
      (exp_in < EXP_HALF): begin
        kind = K_ZERO;
      end
      (exp_in >= EXP_SAT): begin
        kind = K_SAT;
      end
      (exp_in >= EXP_HALF && exp_in < EXP_UNITY): begin
        kind  = K_SHIFT;
        count = 4'(EXP_UNITY - exp_in);
      end
      (exp_in == EXP_UNITY): begin
        kind = K_ROUND;
      end
      (exp_in > EXP_UNITY && exp_in < EXP_SAT): begin
        kind     = K_SHIFT;
        dir_left = 1'b1;
        count    = 4'(exp_in - EXP_UNITY);
      end
      default: begin
        kind = K_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/flt2int.sv
// Serial half-float to sign-magnitude integer converter,
// one shift per clock, round-to-nearest-even.
module flt2int
  import flt2int_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] flt_in,
  output logic        done,
  output logic        busy,
  output logic [15:0] int_out
);

  state_t       r_state;
  state_t       w_next;
  half_t        r_op;
  logic [14:0]  r_w;
  logic [3:0]   r_cnt;
  logic         r_dir;
  logic         r_guard;
  logic         r_sticky;
  logic [15:0]  r_out;

  kind_t        w_kind;
  logic         w_dir;
  logic [3:0]   w_cnt;
  logic         w_inc;

  flt2int_classify u_classify (
    .exp_in   (r_op.exp),
    .kind     (w_kind),
    .dir_left (w_dir),
    .count    (w_cnt)
  );

  assign w_inc   = r_guard & (r_sticky | r_w[0]);
  assign done    = (r_state == DONE);
  assign busy    = (r_state == LOAD) ||
                   (r_state == SHIFT) ||
                   (r_state == ROUND);
  assign int_out = r_out;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) w_next = LOAD;
      end
      LOAD: begin
        unique case (w_kind)
          K_ZERO, K_SAT: w_next = DONE;
          K_ROUND:       w_next = ROUND;
          K_SHIFT:       w_next = SHIFT;
          default:       w_next = DONE;
        endcase
      end
      SHIFT: begin
        if (r_cnt == 4'd1) w_next = ROUND;
      end
      ROUND: begin
        w_next = DONE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_w      <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_out    <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) r_op <= flt_in;
        end
        LOAD: begin
          r_guard  <= 1'b0;
          r_sticky <= 1'b0;
          r_dir    <= w_dir;
          r_cnt    <= w_cnt;
          unique case (w_kind)
            K_ZERO:  r_out <= {r_op.sgn, 15'h0000};
            K_SAT:   r_out <= {r_op.sgn, 15'h7FFF};
            default: r_w   <= {4'b0000, 1'b1, r_op.mant};
          endcase
        end
        SHIFT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_dir) begin
            r_w <= r_w << 1;
          end else begin
            // Bits older than the guard fold into sticky.
            r_sticky <= r_sticky | r_guard;
            r_guard  <= r_w[0];
            r_w      <= r_w >> 1;
          end
        end
        ROUND: begin
          r_out <= {r_op.sgn, r_w + {14'd0, w_inc}};
        end
        default: begin
          r_out <= r_out;
        end
      endcase
    end
  end

endmodule

// File: doc/flt2int.md
Name: flt2int

Overview:
- Converts a 16-bit half-precision float into a 16-bit sign-magnitude integer: sign 1 bit, exponent 5 bits with bias 15, mantissa 10 bits with a hidden 1.
- It is the inverse of the existing int2flt path.
- It uses a serial, one-bit-per-cycle shifter with a start/done handshake.
- It sits beside int2flt as a datapath helper; the host loads operands from data memory and writes the results back.

Parameters:
- BIAS, 15, exponent bias.
- MAG_W, 15, integer magnitude width; the sign is carried separately in bit 15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE or DONE.
- flt_in  input  16  operand {sign, exp[4:0], mant[9:0]}; captured on the accepting edge.
- done  output  1  high while in DONE; int_out is valid and stable.
- busy  output  1  high in LOAD, SHIFT and ROUND.
- int_out  output  16  result {sign, magnitude[14:0]}.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset forces state IDLE, done=0, busy=0, int_out=16'h0000 and clears all working registers. Reset in any state, including mid-conversion, aborts the conversion with no output update.
- States are IDLE, LOAD, SHIFT, ROUND, DONE.
- IDLE/DONE with start=1: capture flt_in into op and go to LOAD. In DONE, this drops done on the same edge.
- IDLE/DONE with start=0: hold state. In DONE, int_out stays stable.
- start while busy: ignored.
- LOAD classifies op (e=exp, m=mant):
  - e=0 (zero/denormal flushed): magnitude 0, go to DONE.
  - 1<=e<=13 (value below 0.5): magnitude 0, go to DONE.
  - e>=30, including 31 (Inf/NaN): saturate magnitude to 15'h7FFF, go to DONE.
  - 14<=e<=24: W={1,m} with guard=0 and sticky=0; right-shift count=25-e (1..11); go to SHIFT.
  - e=25: count=0; go directly to ROUND.
  - 26<=e<=29: left-shift count=e-25 (1..4); go to SHIFT.
- SHIFT shifts one position per edge and decrements count. On the edge where count reaches 0, go to ROUND.
  - Right shift: sticky |= guard, guard <= W[0], W >>= 1.
  - Left shift: W <<= 1 with zero fill.
- ROUND applies round-to-nearest-even: W += guard & (sticky | W[0]). It then writes int_out={op[15], W[14:0]} and goes to DONE.
  - Rounding never overflows 15 bits (W < 2^10 whenever right shifts occurred).
  - The maximum exact value is e=29, m=3FF, giving 32752.
- The sign always passes through, including zero and saturation results (-0 gives 16'h8000).
- Latency, counted from the start-accepting edge to the first cycle with done=1:
  - 3 + shift count in the normal path.
  - 2 in the shortcut paths (zero, below 0.5, saturate).
- Back-to-back operation: start asserted during DONE restarts immediately, and done is low for the whole new conversion.
- busy and done are never high simultaneously.

Decomposition:
- Package flt2int_pkg holds:
  - the state enum state_t (IDLE, LOAD, SHIFT, ROUND, DONE);
  - the constants BIAS=15, EXP_W=5, MANT_W=10, EXP_SAT=30, EXP_UNITY=25, EXP_HALF=14;
  - a packed struct half_t {sgn, exp, mant}.
- One combinational sub-module, flt2int_classify, maps exp to {kind, dir, count}. The FSM and shifter stay in the top module.

Test Plan:
- 16'h3C00 (1.0): done after 13 cycles, int_out=16'h0001. Also 16'hBC00 gives 16'h8001.
- Ties to even:
  - 16'h3E00 (1.5) gives 16'h0002.
  - 16'h4100 (2.5) gives 16'h0002.
  - 16'h3800 (0.5) gives 16'h0000.
  - 16'h3801 (just above 0.5) gives 16'h0001.
- Large exact values:
  - 16'h77FF gives 16'h7FF0 (32752) with latency 7.
  - 16'h6400 (e=25) gives 16'h0400 (1024) with latency 3.
- Shortcuts, each with latency 2:
  - 16'h7800 (e=30) gives 16'h7FFF.
  - 16'hFC00 gives 16'hFFFF.
  - 16'h0000 gives 16'h0000.
  - 16'h3400 (0.25) gives 16'h0000.
- Protocol:
  - start pulsed during SHIFT is ignored.
  - start held in DONE launches the next conversion and done falls on the next edge.
  - reset asserted in SHIFT gives IDLE, int_out=0, done=0 on the next edge.
- Random sweep: a random finite flt_in is compared against a reference model of round-to-nearest-even(value) with sign-magnitude packing. Run at least 500 vectors with zero mismatches.
